uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver with runtime frame configuration.
//
// Oversamples the line with the system clock. Each bit is sampled at its
// middle, measured from the detected falling edge of the start bit. Supports
// 5..8 data bits, optional odd/even parity, and 1 or 2 stop bits. The frame
// configuration is captured when the start edge is seen, so later changes
// to cfg_reg_in do not affect a frame that is already in progress.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN - each bit decision is the 2-of-3 majority of the
//                         synchronized line at ticks mid-1, mid and mid+1.
//                         When undefined, the single mid-tick value is used.
//
// Parameters:
//   CLK_FREQ_HZ        system clock frequency in Hz
//   BAUD_RATE          line bit rate
//
// Ports:
//   clk                system clock, rising edge
//   rst_n              asynchronous active-low reset
//   rxd_in             serial line (asynchronous, idle high)
//   cfg_reg_in[4:0]    [1:0] data bits-5, [2] two stop bits,
//                      [3] parity enable, [4] parity even(1)/odd(0)
//   rx_data_out[7:0]   last received character, LSB-aligned
//   rx_done_out        one-cycle pulse per completed frame
//   parity_error_out   parity mismatch of the last frame
//   framing_error_out  a stop bit of the last frame was sampled low
//   rx_busy_out        high from start detection through the done cycle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd_in,
   input  logic [4:0] cfg_reg_in,
   output logic [7:0] rx_data_out,
   output logic       rx_done_out,
   output logic       parity_error_out,
   output logic       framing_error_out,
   output logic       rx_busy_out
);

   localparam int BIT_TICKS = CLK_FREQ_HZ / BAUD_RATE;
   localparam int HALF      = BIT_TICKS / 2;
   localparam int CNT_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   // Line synchronizer and one-cycle history of the synchronized value
   logic       sync1_q;
   logic       sync2_q;
   logic       prev_q;

   state_t     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0] bit_idx_q;
   logic [2:0] last_idx_q;
   logic       stop2_q;
   logic       stop_idx_q;
   logic       par_en_q;
   logic       par_even_q;
   logic [7:0] shreg_q;
   logic       par_acc_q;
   logic       perr_q;
   logic       ferr_q;

   logic [7:0] data_q;
   logic       done_q;
   logic       perr_out_q;
   logic       ferr_out_q;
   logic       busy_q;

   logic       bit_d;
   logic       tick_d;

   // sync1_q already holds the value sync2_q will take on the next tick, so
   // (prev_q, sync2_q, sync1_q) is the synchronized line at mid-1, mid, mid+1
   // without delaying the decision.
`ifdef UART_RX_MAJORITY_EN
   assign bit_d = (prev_q & sync2_q) | (prev_q & sync1_q) | (sync2_q & sync1_q);
`else
   assign bit_d = sync2_q;
`endif

   // Start bit is sampled half a bit after the edge; every later bit one
   // full bit time after the previous sample.
   assign tick_d = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == BIT_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         last_idx_q <= '0;
         stop2_q    <= 1'b0;
         stop_idx_q <= 1'b0;
         par_en_q   <= 1'b0;
         par_even_q <= 1'b0;
         shreg_q    <= '0;
         par_acc_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         sync1_q <= rxd_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         done_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               // A held-low line (break) never produces a 1->0 transition,
               // so no new frame starts until it returns high and falls.
               if (prev_q && !sync2_q) begin
                  state_q    <= START;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  bit_idx_q  <= '0;
                  last_idx_q <= {1'b0, cfg_reg_in[1:0]} + 3'd4;
                  stop2_q    <= cfg_reg_in[2];
                  par_en_q   <= cfg_reg_in[3];
                  par_even_q <= cfg_reg_in[4];
                  stop_idx_q <= 1'b0;
                  shreg_q    <= '0;
                  par_acc_q  <= 1'b0;
                  perr_q     <= 1'b0;
                  ferr_q     <= 1'b0;
               end
            end

            START: begin
               if (tick_d) begin
                  cnt_q <= '0;
                  if (bit_d) begin
                     // Line back high at mid start bit: treat as a glitch
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            DATA: begin
               if (tick_d) begin
                  cnt_q              <= '0;
                  shreg_q[bit_idx_q] <= bit_d;
                  par_acc_q          <= par_acc_q ^ bit_d;
                  if (bit_idx_q == last_idx_q) begin
                     state_q <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            PARITY: begin
               if (tick_d) begin
                  cnt_q   <= '0;
                  // XOR of data+parity must be 1 for odd, 0 for even
                  perr_q  <= par_acc_q ^ bit_d ^ ~par_even_q;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            STOP: begin
               if (tick_d) begin
                  cnt_q <= '0;
                  if (stop2_q && !stop_idx_q) begin
                     stop_idx_q <= 1'b1;
                     if (!bit_d) begin
                        ferr_q <= 1'b1;
                     end
                  end else begin
                     state_q    <= IDLE;
                     done_q     <= 1'b1;
                     data_q     <= shreg_q;
                     perr_out_q <= perr_q;
                     ferr_out_q <= ferr_q | ~bit_d;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data_out       = data_q;
   assign rx_done_out       = done_q;
   assign parity_error_out  = perr_out_q;
   assign framing_error_out = ferr_out_q;
   assign rx_busy_out       = busy_q;

endmodule
